prime_sweep_ctrl: RTL
=====================

// Module: prime_sweep_ctrl
// PURPOSE
//   Self-test sequencer that drives the 3-bit prime number detector and collects its results.
//   On start it sweeps every input code 0..2^WIDTH-1 onto the detector inputs.
//   Each code is held for SETTLE_CYCLES, then the detector output p is sampled.
//   Results are stored as a per-code mask and a prime count, and compared against a golden mask.
//   Sits directly upstream of the detector (feeds a,b,c) and downstream of it (consumes p).
// PARAMETERS
//   WIDTH          3            code width; sweep covers N = 2**WIDTH codes
//   SETTLE_CYCLES  2            cycles each code is held before sampling (>=1)
//   EXPECTED_MASK  8'b1010_1100 golden result mask; bit k = detector output for code k (primes 2,3,5,7)
// PORTS
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      sweep request; level-sampled, acted on only in IDLE or DONE
//   code         out  WIDTH  code driven to the detector; code[0]=a, code[1]=b, code[2]=c
//   p_in         in   1      detector output; sampled only in SAMPLE
//   busy         out  1      high in DRIVE and SAMPLE
//   done         out  1      high while in DONE
//   prime_mask   out  N      bit k = p_in captured while code==k
//   prime_count  out  WIDTH+1  number of set bits in prime_mask
//   mismatch     out  1      prime_mask != EXPECTED_MASK; valid while done=1
// BEHAVIOUR
//   Reset (async assert, sync deassert at the next clk edge):
//     - State goes to IDLE.
//     - code, busy, done, prime_mask, prime_count, mismatch and the settle counter all go to 0.
//   All outputs are registered.
//   FSM states: IDLE, DRIVE, SAMPLE, DONE.
//   IDLE:
//     - If start=1: clear prime_mask, prime_count and mismatch; set code=0 and cnt=0; go to DRIVE.
//   DRIVE:
//     - Hold code.
//     - While cnt < SETTLE_CYCLES-1: cnt++.
//     - Otherwise go to SAMPLE.
//   SAMPLE (exactly 1 cycle):
//     - prime_mask[code] <= p_in.
//     - prime_count <= prime_count + p_in.
//     - If code == N-1: go to DONE, and mismatch <= ({p_in, prime_mask[N-2:0]} != EXPECTED_MASK).
//     - Otherwise: code++, cnt=0, go to DRIVE.
//   DONE:
//     - done=1; results hold; code holds at N-1.
//     - If start=1: same action as IDLE+start; done drops on that edge.
//   Latency: DONE is entered N*(SETTLE_CYCLES+1) edges after the edge that sampled start.
//     With defaults this is 24.
//   start while busy=1 is ignored; the sweep is not restarted or extended.
//   p_in outside SAMPLE is don't-care and must not affect any state.
//     X on p_in outside SAMPLE must not propagate.
//   start held high continuously: back-to-back sweeps; done is high for exactly 1 cycle between them.
//   rst_n low mid-sweep:
//     - Immediate abort with all outputs at reset values.
//     - Partial results are discarded.
//     - A new start is required to resume.
//   prime_count cannot overflow: max value is N, and its width is WIDTH+1.
//   code increments without wrap; the SAMPLE-at-N-1 exit precedes any increment.
// STRUCTURE
//   Package prime_sweep_pkg holds:
//     - the sweep_state_t enum {IDLE, DRIVE, SAMPLE, DONE};
//     - the constant PRIME3_GOLDEN = 8'hAC.
//   Single module, no sub-module: FSM, settle counter, code register and result registers.
//   The top level and the bench instantiate the detector beside this block:
//     code[0]->a, code[1]->b, code[2]->c, p->p_in.
// TESTING
//   T1: reset, 1-cycle start pulse, real detector attached
//       -> done rises 24 cycles later; prime_mask=8'hAC, prime_count=4, mismatch=0.
//   T2: p_in forced to 1
//       -> prime_mask=8'hFF, prime_count=8, mismatch=1.
//   T3: p_in forced to 0
//       -> prime_mask=8'h00, prime_count=0, mismatch=1.
//   T4: second start pulse 10 cycles into the sweep
//       -> ignored; done still at cycle 24; results identical to T1.
//   T5: rst_n low at cycle 12
//       -> all outputs 0 asynchronously; state stays IDLE (busy=0) until the next start.
//       -> A fresh sweep then reproduces T1.
//   T6: start held high; p_in toggled every cycle outside SAMPLE
//       -> each code held exactly 3 cycles; mask matches the T1 value.
//       -> done high 1 cycle, then the next sweep begins.

Source files
------------

// File: rtl/prime_sweep_pkg.sv
// Shared types and constants for the prime detector self-test sequencer.
package prime_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } sweep_state_t;

    // Expected detector response for codes 0..7: primes 2, 3, 5 and 7.
    localparam logic [7:0] PRIME3_GOLDEN = 8'hAC;

endpackage

// File: rtl/prime_sweep_ctrl.sv
// Sweeps every code onto the prime detector, captures its response per code,
// counts primes and flags any disagreement with the golden mask.
module prime_sweep_ctrl
    import prime_sweep_pkg::*;
#(
    parameter int                      WIDTH         = 3,
    parameter int                      SETTLE_CYCLES = 2,
    parameter logic [(1<<WIDTH)-1:0]   EXPECTED_MASK = PRIME3_GOLDEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [WIDTH-1:0]      code,
    input  logic                  p_in,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<WIDTH)-1:0] prime_mask,
    output logic [WIDTH:0]        prime_count,
    output logic                  mismatch
);

    localparam int N  = 1 << WIDTH;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CW-1:0]    CNT_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] CODE_LAST = WIDTH'(N - 1);

    sweep_state_t     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [N-1:0]     mask_q, mask_d;
    logic [WIDTH:0]   count_q, count_d;
    logic             mism_q, mism_d;
    logic             busy_q, done_q;

    // p_in is only read in SAMPLE so an undriven or toggling detector
    // cannot disturb the results between samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        mask_d  = mask_q;
        count_d = count_q;
        mism_d  = mism_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    code_d  = '0;
                    mask_d  = '0;
                    count_d = '0;
                    mism_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                mask_d[code_q] = p_in;
                count_d        = count_q + {{WIDTH{1'b0}}, p_in};
                if (code_q == CODE_LAST) begin
                    state_d = DONE;
                    mism_d  = (mask_d != EXPECTED_MASK);
                end else begin
                    state_d = DRIVE;
                    code_d  = code_q + WIDTH'(1);
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
            mism_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            mism_q  <= mism_d;
            busy_q  <= (state_d == DRIVE) || (state_d == SAMPLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign code        = code_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign prime_mask  = mask_q;
    assign prime_count = count_q;
    assign mismatch    = mism_q;

endmodule
